pci_burst_master: RTL and testbench
===================================

// Module: pci_burst_master
// PURPOSE
//  Synthesizable, parametrised user-side master for the PCI core's initiator port.
//  Takes queued commands of 1..DEPTH dwords and buffers write data before requesting the bus.
//  Collects read data into the same buffer, then drains it to the user.
//  Restarts at the first untransferred dword after disconnect/retry; ends aborts with a status code, no dead state.
// PARAMETERS
//  DEPTH      16   buffer depth in dwords = max burst length (power of 2, 2..256)
//  LEN_W       5   width of cmd_len; must equal clog2(DEPTH)+1
//  MAX_RETRY   8   consecutive no-progress attempts allowed before giving up (1..255)
// PORTS
//  CLK          in   1      core clock
//  reset        in   1      synchronous, active-high reset
//  cmd_valid    in   1      command offered
//  cmd_ready    out  1      command accepted when valid&ready (high only in S_IDLE)
//  cmd_addr     in   32     start byte address, [1:0] ignored (forced 00)
//  cmd_write    in   1      1 = memory write, 0 = memory read
//  cmd_len      in   LEN_W  dword count, 1..DEPTH; 0 or >DEPTH ends with status 2'b11, no bus cycle
//  wr_valid     in   1      write data offered (S_FILL only)
//  wr_ready     out  1      write data accepted when valid&ready
//  wr_data      in   32     write dword
//  rd_valid     out  1      read dword presented (S_DRAIN); no backpressure
//  rd_data      out  32     read dword
//  done         out  1      one-cycle pulse at command end
//  status       out  2      valid with done: 00 ok, 01 retries exhausted, 10 abort, 11 bad length
//  xfer_cnt     out  LEN_W  dwords actually transferred, valid with done
//  adio_out     in   32     core read data / address bus
//  adio_in      out  32     address in address phase, write data in data phase, else 0
//  m_data       in   1      core in data phase
//  m_data_vld   in   1      a data phase completed this cycle
//  m_addr_n     in   1      low during address phase
//  csr          in   40     core status; [39]/[38] master/target abort, [36] retry
//  complete     out  1      last dword of the current attempt
//  m_ready      out  1      master ready for data
//  m_cbe        out  4      command in address phase, byte enables (4'b0000) otherwise
//  m_wrdn       out  1      1 = write
//  request      out  1      bus request, one cycle per attempt
//  requesthold  out  1      tied 0
// BEHAVIOUR
//  Reset: state S_IDLE; cmd_ready=1; all other outputs 0; pointers, counters and status cleared.
//  Reset mid-transfer abandons the command without a done pulse.
//  States:
//   S_IDLE : cmd handshake latches addr/len/dir; next S_FILL if write, S_REQ if read; bad len -> S_DONE(11).
//   S_FILL : accepts len dwords into buffer[0..len-1]; wr_ready=1 until count==len; then S_REQ.
//   S_REQ  : request=1 for exactly one cycle; next S_XFER.
//   S_XFER : adio_in=cur_addr while ~m_addr_n.
//            m_cbe = 4'h6 read single, 4'hC read len>1, 4'h7 write.
//            Each m_data_vld advances ptr and cur_addr+=4; a read stores adio_out at buffer[ptr].
//            Write drives buffer[ptr] while m_data.
//            Exit on falling edge of m_data (m_data registered) -> S_CHK.
//   S_CHK  : abort flag (csr[39]|csr[38] sampled while m_data) -> S_DONE(10).
//            Otherwise ptr==len -> S_DRAIN if read, else S_DONE(00).
//            Otherwise retry path: rty_cnt increments if no dword moved this attempt, clears if any did.
//            rty_cnt==MAX_RETRY -> S_DONE(01); else S_REQ, resuming at buffer[ptr]/cur_addr.
//   S_DRAIN: rd_valid=1, rd_data=buffer[i] for i=0..ptr-1, one per cycle; then S_DONE(00).
//   S_DONE : done=1, status/xfer_cnt valid for one cycle; next S_IDLE.
//  Reads that end with 01/10 still drain the dwords received before done.
//  complete=1 in S_REQ/S_XFER when len-ptr<=1, and when m_data_vld fires with len-ptr==2.
//  m_ready=1 from the first cycle after reset release. m_wrdn=latched dir, stable for the whole command.
//  Abort flag and per-attempt progress flag clear when ~m_addr_n.
//  m_data_vld outside S_XFER is ignored. m_data_vld when ptr==len is ignored (no overrun, ptr saturates).
//  cur_addr wraps modulo 2^32. LEN_W arithmetic is unsigned; buffer index is ptr[LEN_W-2:0].
// STRUCTURE
//  pci_mst_pkg.vh  : state codes, CBE codes (6/C/7), status codes, clog2 function.
//  pci_mst_buf     : DEPTH x 32 single-clock RAM, 1 write port, async read port.
//                    Shared by fill/read-capture and by write-drive/drain.
//  Top level holds the FSM, ptr/len/rty counters, cur_addr and the core-side muxes.
// TESTING
//  1 read len=1 @0x1000, target returns 0xDEADBEEF -> cbe 6 in addr phase;
//    rd_data=0xDEADBEEF; done, status 00, xfer_cnt 1.
//  2 write len=4 {1,2,3,4} @0x2000 -> 4 data phases carry 1..4 in order; done 00, xfer_cnt 4.
//  3 read len=8, disconnect after 3 dwords -> second request addressed 0x200C;
//    8 dwords drained in order; done 00.
//  4 write len=2, csr[36] retry with no data on 8 consecutive attempts (MAX_RETRY=8)
//    -> done status 01, xfer_cnt 0, back to S_IDLE.
//  5 read len=4, csr[38] after 1 dword -> done status 10, xfer_cnt 1, one rd_valid beat;
//    next command accepted.
//  6 cmd_len=0 -> done status 11 with no request; reset asserted mid-S_XFER
//    -> request/cmd state cleared, cmd_ready=1 next cycle.

Source files
------------

// File: rtl/pci_burst_master_pkg.sv
// Shared definitions for the PCI burst master.
//   state_t      : master FSM state codes
//   CBE_*        : PCI command codes driven on m_cbe during the address phase
//   ST_*         : completion status codes reported with done
//   clog2()      : ceiling log2, used to size the buffer index
package pci_burst_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_REQ   = 3'd2,
    S_XFER  = 3'd3,
    S_CHK   = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [3:0] CBE_RD_SINGLE = 4'h6;
  localparam logic [3:0] CBE_RD_MULT   = 4'hC;
  localparam logic [3:0] CBE_WR        = 4'h7;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_RETRY  = 2'b01;
  localparam logic [1:0] ST_ABORT  = 2'b10;
  localparam logic [1:0] ST_BADLEN = 2'b11;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/pci_burst_master_buf.sv
// DEPTH x 32 single-clock buffer, one synchronous write port and one
// asynchronous read port. Holds write data before the bus cycle and read
// data captured from the bus until it is drained to the user.
//   CLK   : clock
//   we    : write enable
//   waddr : write index
//   wdata : write dword
//   raddr : read index
//   rdata : read dword (combinational)
module pci_burst_master_buf
  import pci_burst_master_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pci_burst_master.sv
// User-side burst master for the PCI core initiator port.
// Accepts a command of 1..DEPTH dwords, buffers write data, requests the bus,
// resumes after disconnect/retry from the first untransferred dword, and
// drains captured read data to the user. Ends every command with a one-cycle
// done pulse carrying status and the number of dwords moved.
// Ports:
//   CLK, reset                  : clock, synchronous active-high reset
//   cmd_valid/ready/addr/write/len : command handshake
//   wr_valid/ready/data         : write data into the buffer (S_FILL)
//   rd_valid/rd_data            : read data out of the buffer (S_DRAIN)
//   done/status/xfer_cnt        : command completion report
//   adio_out/adio_in            : core data/address buses
//   m_data/m_data_vld/m_addr_n  : core phase indicators
//   csr                         : core status ([39]/[38] aborts)
//   complete/m_ready/m_cbe/m_wrdn/request/requesthold : core controls
// Handshakes: a transfer happens on a rising CLK edge where both valid and
// ready are high; valid may not depend on ready, and rd_valid has no
// backpressure (the user must take every beat).
module pci_burst_master
  import pci_burst_master_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int LEN_W     = 5,
  parameter int MAX_RETRY = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic             cmd_write,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [31:0]      wr_data,
  output logic             rd_valid,
  output logic [31:0]      rd_data,
  output logic             done,
  output logic [1:0]       status,
  output logic [LEN_W-1:0] xfer_cnt,
  input  logic [31:0]      adio_out,
  output logic [31:0]      adio_in,
  input  logic             m_data,
  input  logic             m_data_vld,
  input  logic             m_addr_n,
  input  logic [39:0]      csr,
  output logic             complete,
  output logic             m_ready,
  output logic [3:0]       m_cbe,
  output logic             m_wrdn,
  output logic             request,
  output logic             requesthold
);

  localparam int AW = LEN_W - 1;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t state, state_nxt;

  logic [31:0]      cur_addr;
  logic [LEN_W-1:0] len_q, ptr, drain_idx, remain;
  logic             dir_q, abort_q, prog_q, m_data_q, m_ready_q;
  logic [7:0]       rty_cnt, rty_next;
  logic [1:0]       status_q, status_val;
  logic             status_set;
  logic             cmd_fire, wr_fire, vld_fire, len_bad, addr_ph;
  state_t           end_state;
  logic [3:0]       cmd_cbe;
  logic             buf_we;
  logic [AW-1:0]    buf_raddr;
  logic [31:0]      buf_wdata, buf_rdata;
  logic             unused_ok;

  assign cmd_fire = cmd_valid && (state == S_IDLE);
  assign wr_fire  = wr_valid && wr_ready;
  // Data phases beyond the requested length are dropped so ptr saturates.
  assign vld_fire = (state == S_XFER) && m_data_vld && (ptr != len_q);
  assign len_bad  = (cmd_len == '0) || (cmd_len > LEN_W'(DEPTH));
  assign addr_ph  = (state == S_XFER) && !m_addr_n;
  assign remain   = len_q - ptr;
  // Reads with data already captured drain it even when the command failed.
  assign end_state = (!dir_q && (ptr != '0)) ? S_DRAIN : S_DONE;

  always_comb begin
    state_nxt  = state;
    status_set = 1'b0;
    status_val = ST_OK;
    rty_next   = rty_cnt;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    request    = 1'b0;
    rd_valid   = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (len_bad) begin
            state_nxt  = S_DONE;
            status_set = 1'b1;
            status_val = ST_BADLEN;
          end else if (cmd_write) begin
            state_nxt = S_FILL;
          end else begin
            state_nxt = S_REQ;
          end
        end
      end
      S_FILL: begin
        wr_ready = (ptr != len_q);
        if (ptr == len_q) state_nxt = S_REQ;
      end
      S_REQ: begin
        request   = 1'b1;
        state_nxt = S_XFER;
      end
      S_XFER: begin
        // Attempt ends when the core leaves the data phase.
        if (m_data_q && !m_data) state_nxt = S_CHK;
      end
      S_CHK: begin
        rty_next = prog_q ? 8'd0 : rty_cnt + 8'd1;
        if (abort_q) begin
          status_set = 1'b1;
          status_val = ST_ABORT;
          state_nxt  = end_state;
        end else if (ptr == len_q) begin
          status_set = 1'b1;
          status_val = ST_OK;
          state_nxt  = end_state;
        end else if (rty_next == 8'(MAX_RETRY)) begin
          status_set = 1'b1;
          status_val = ST_RETRY;
          state_nxt  = end_state;
        end else begin
          state_nxt = S_REQ;
        end
      end
      S_DRAIN: begin
        rd_valid = 1'b1;
        if (drain_idx == ptr - LEN_ONE) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      cur_addr  <= '0;
      len_q     <= '0;
      ptr       <= '0;
      drain_idx <= '0;
      dir_q     <= 1'b0;
      abort_q   <= 1'b0;
      prog_q    <= 1'b0;
      m_data_q  <= 1'b0;
      m_ready_q <= 1'b0;
      rty_cnt   <= '0;
      status_q  <= ST_OK;
    end else begin
      m_data_q  <= m_data;
      m_ready_q <= 1'b1;
      if (status_set) status_q <= status_val;
      // Abort and progress flags are per attempt: a new address phase clears them.
      if (!m_addr_n) begin
        abort_q <= 1'b0;
        prog_q  <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            cur_addr <= {cmd_addr[31:2], 2'b00};
            len_q    <= cmd_len;
            dir_q    <= cmd_write;
            ptr      <= '0;
            rty_cnt  <= '0;
            abort_q  <= 1'b0;
            prog_q   <= 1'b0;
          end
        end
        S_FILL: begin
          if (wr_fire)            ptr <= ptr + LEN_ONE;
          else if (ptr == len_q)  ptr <= '0;
        end
        S_XFER: begin
          if (m_data && (csr[39] || csr[38])) abort_q <= 1'b1;
          if (vld_fire) begin
            ptr      <= ptr + LEN_ONE;
            cur_addr <= cur_addr + 32'd4;
            prog_q   <= 1'b1;
          end
        end
        S_CHK: begin
          rty_cnt   <= rty_next;
          drain_idx <= '0;
        end
        S_DRAIN: drain_idx <= drain_idx + LEN_ONE;
        default: ;
      endcase
    end
  end

  // The buffer serves fill and read capture on the write port, and write
  // drive and drain on the read port; the states never overlap.
  assign buf_we    = wr_fire || (vld_fire && !dir_q);
  assign buf_wdata = (state == S_FILL) ? wr_data : adio_out;
  assign buf_raddr = (state == S_DRAIN) ? drain_idx[AW-1:0] : ptr[AW-1:0];

  pci_burst_master_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .CLK   (CLK),
    .we    (buf_we),
    .waddr (ptr[AW-1:0]),
    .wdata (buf_wdata),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  assign cmd_cbe = dir_q ? CBE_WR : ((len_q == LEN_ONE) ? CBE_RD_SINGLE : CBE_RD_MULT);

  assign adio_in  = addr_ph ? cur_addr :
                    ((state == S_XFER) && dir_q && m_data) ? buf_rdata : 32'd0;
  assign m_cbe    = addr_ph ? cmd_cbe : 4'h0;
  // Last dword of this attempt: one left, or two left with one completing now.
  assign complete = ((state == S_REQ) || (state == S_XFER)) &&
                    ((remain <= LEN_ONE) || (m_data_vld && (remain == LEN_W'(2))));
  assign m_ready     = m_ready_q;
  assign m_wrdn      = dir_q;
  assign requesthold = 1'b0;
  assign rd_data     = rd_valid ? buf_rdata : 32'd0;
  assign status      = done ? status_q : 2'b00;
  assign xfer_cnt    = done ? ptr : '0;

  assign unused_ok = ^{csr[37:0], cmd_addr[1:0]};

endmodule

// File: tb/tb_pci_burst_master.sv
module tb_pci_burst_master;

  logic        CLK, reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [4:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done;
  logic [1:0]  status;
  logic [4:0]  xfer_cnt;
  logic [31:0] adio_out, adio_in;
  logic        m_data, m_data_vld, m_addr_n;
  logic [39:0] csr;
  logic        complete, m_ready, m_wrdn, request, requesthold;
  logic [3:0]  m_cbe;

  pci_burst_master #(.DEPTH(16), .LEN_W(5), .MAX_RETRY(8)) dut (
    .CLK(CLK), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .status(status), .xfer_cnt(xfer_cnt),
    .adio_out(adio_out), .adio_in(adio_in),
    .m_data(m_data), .m_data_vld(m_data_vld), .m_addr_n(m_addr_n), .csr(csr),
    .complete(complete), .m_ready(m_ready), .m_cbe(m_cbe), .m_wrdn(m_wrdn),
    .request(request), .requesthold(requesthold)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] dat [16];
  int bptr;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [4:0]  len;
    logic [31:0] dbase;
    logic [31:0] exp_addr;
    logic [3:0]  exp_cbe;
    logic [1:0]  exp_st;
    logic [4:0]  exp_xfer;
  } vec_t;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [4:0] l);
    int t;
    t = 0;
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    #1;
    while (!cmd_ready && t < 40) begin @(negedge CLK); #1; t++; end
    chk("cmd_ready", 40'(cmd_ready), 40'(1));
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic fill(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      @(negedge CLK);
      wr_valid = 1'b1; wr_data = dat[i];
      #1;
      while (!wr_ready && t < 40) begin @(negedge CLK); #1; t++; end
      chk("wr_ready", 40'(wr_ready), 40'(1));
    end
    @(negedge CLK);
    wr_valid = 1'b0;
  endtask

  task automatic wait_request(input int len);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(negedge CLK); #1;
      if (request) seen = 1'b1;
    end
    chk("request_seen", 40'(seen), 40'(1));
    chk("complete_req", 40'(complete), 40'((len - bptr) <= 1));
  endtask

  // Core model for one attempt: address phase, nd data phases, optional
  // extra data-phase cycle with no transfer carrying tcsr, then data phase ends.
  task automatic core_attempt(input logic [31:0] ea, input logic [3:0] ecbe,
                              input logic is_wr, input int len, input int nd,
                              input logic tail, input logic [39:0] tcsr);
    @(negedge CLK);
    m_addr_n = 1'b0;
    #1;
    chk("addr_phase_adio", 40'(adio_in), 40'(ea));
    chk("addr_phase_cbe", 40'(m_cbe), 40'(ecbe));
    chk("m_wrdn", 40'(m_wrdn), 40'(is_wr));
    for (int k = 0; k < nd; k++) begin
      @(negedge CLK);
      m_addr_n = 1'b1; m_data = 1'b1; m_data_vld = 1'b1;
      adio_out = is_wr ? 32'h0 : dat[bptr];
      #1;
      if (is_wr) chk("wr_data_phase", 40'(adio_in), 40'(dat[bptr]));
      chk("complete_vld", 40'(complete), 40'((len - bptr) <= 2));
      bptr++;
    end
    if (tail) begin
      @(negedge CLK);
      m_addr_n = 1'b1; m_data = 1'b1; m_data_vld = 1'b0; csr = tcsr; adio_out = 32'h0;
    end
    @(negedge CLK);
    m_addr_n = 1'b1; m_data = 1'b0; m_data_vld = 1'b0; csr = 40'h0; adio_out = 32'h0;
  endtask

  task automatic collect_end(input logic [1:0] est, input logic [4:0] exf, input int nbeat);
    int beats, stray;
    bit seen;
    beats = 0; stray = 0; seen = 1'b0;
    for (int t = 0; t < 80 && !seen; t++) begin
      @(negedge CLK); #1;
      if (request) stray++;
      if (rd_valid) begin
        beats++;
        chk("rd_q_nonempty", 40'(exp_q.size() != 0), 40'(1));
        if (exp_q.size() != 0) chk("rd_data", 40'(rd_data), 40'(exp_q.pop_front()));
      end
      if (done) begin
        seen = 1'b1;
        chk("done_status", 40'(status), 40'(est));
        chk("done_xfer_cnt", 40'(xfer_cnt), 40'(exf));
      end
    end
    chk("done_seen", 40'(seen), 40'(1));
    chk("rd_beats", 40'(beats), 40'(nbeat));
    chk("stray_requests", 40'(stray), 40'(0));
    exp_q.delete();
  endtask

  task automatic set_data(input logic [31:0] base, input int n);
    for (int j = 0; j < n; j++) dat[j] = base + 32'(j);
    bptr = 0;
  endtask

  // stimulus
  initial begin
    vec_t vt[8];
    vt[0] = '{1'b0, 32'h0000_1000, 5'd1,  32'hDEAD_BEEF, 32'h0000_1000, 4'h6, 2'b00, 5'd1};
    vt[1] = '{1'b1, 32'h0000_2000, 5'd4,  32'h0000_0001, 32'h0000_2000, 4'h7, 2'b00, 5'd4};
    vt[2] = '{1'b1, 32'h0000_4003, 5'd16, 32'hA000_0000, 32'h0000_4000, 4'h7, 2'b00, 5'd16};
    vt[3] = '{1'b0, 32'h0000_8000, 5'd16, 32'h5500_0000, 32'h0000_8000, 4'hC, 2'b00, 5'd16};
    vt[4] = '{1'b0, 32'h0000_1234, 5'd0,  32'h0,         32'h0,         4'h0, 2'b11, 5'd0};
    vt[5] = '{1'b0, 32'h0000_1234, 5'd17, 32'h0,         32'h0,         4'h0, 2'b11, 5'd0};
    vt[6] = '{1'b1, 32'h0000_1234, 5'd31, 32'h0,         32'h0,         4'h0, 2'b11, 5'd0};
    vt[7] = '{1'b0, 32'h0000_9008, 5'd2,  32'h0000_0077, 32'h0000_9008, 4'hC, 2'b00, 5'd2};

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    adio_out = '0; m_data = 1'b0; m_data_vld = 1'b0; m_addr_n = 1'b1; csr = '0;
    bptr = 0;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_cmd_ready", 40'(cmd_ready), 40'(1));
    chk("rst_request", 40'(request), 40'(0));
    chk("rst_m_ready", 40'(m_ready), 40'(0));
    chk("rst_done", 40'(done), 40'(0));
    chk("rst_rd_valid", 40'(rd_valid), 40'(0));
    chk("rst_adio_in", 40'(adio_in), 40'(0));
    chk("rst_m_cbe", 40'(m_cbe), 40'(0));
    chk("rst_requesthold", 40'(requesthold), 40'(0));
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK); #1;
    chk("m_ready_after_reset", 40'(m_ready), 40'(1));

    // table of single-attempt commands
    for (int i = 0; i < 8; i++) begin
      if (vt[i].exp_st == 2'b11) begin
        bptr = 0;
        send_cmd(vt[i].wr, vt[i].addr, vt[i].len);
        collect_end(2'b11, 5'd0, 0);
      end else begin
        set_data(vt[i].dbase, int'(vt[i].len));
        send_cmd(vt[i].wr, vt[i].addr, vt[i].len);
        if (vt[i].wr) fill(int'(vt[i].len));
        wait_request(int'(vt[i].len));
        core_attempt(vt[i].exp_addr, vt[i].exp_cbe, vt[i].wr, int'(vt[i].len),
                     int'(vt[i].len), 1'b0, 40'h0);
        if (!vt[i].wr) for (int j = 0; j < int'(vt[i].len); j++) exp_q.push_back(dat[j]);
        collect_end(vt[i].exp_st, vt[i].exp_xfer, vt[i].wr ? 0 : int'(vt[i].len));
      end
    end

    // read len 8, disconnect after 3 dwords, resume at 0x200C
    set_data(32'h3000_0000, 8);
    send_cmd(1'b0, 32'h0000_2000, 5'd8);
    wait_request(8);
    core_attempt(32'h0000_2000, 4'hC, 1'b0, 8, 3, 1'b0, 40'h0);
    wait_request(8);
    core_attempt(32'h0000_200C, 4'hC, 1'b0, 8, 5, 1'b0, 40'h0);
    for (int j = 0; j < 8; j++) exp_q.push_back(dat[j]);
    collect_end(2'b00, 5'd8, 8);

    // read across the 4 GiB boundary: second attempt addresses 0x0
    set_data(32'h0BAD_0000, 2);
    send_cmd(1'b0, 32'hFFFF_FFFC, 5'd2);
    wait_request(2);
    core_attempt(32'hFFFF_FFFC, 4'hC, 1'b0, 2, 1, 1'b0, 40'h0);
    wait_request(2);
    core_attempt(32'h0000_0000, 4'hC, 1'b0, 2, 1, 1'b0, 40'h0);
    exp_q.push_back(dat[0]); exp_q.push_back(dat[1]);
    collect_end(2'b00, 5'd2, 2);

    // write len 2, eight retries with no data -> status 01
    set_data(32'h0000_0011, 2);
    send_cmd(1'b1, 32'h0000_5000, 5'd2);
    fill(2);
    for (int a = 0; a < 8; a++) begin
      wait_request(2);
      core_attempt(32'h0000_5000, 4'h7, 1'b1, 2, 0, 1'b1, 40'h10_0000_0000);
    end
    collect_end(2'b01, 5'd0, 0);

    // read len 4, target abort after one dword -> status 10, one beat
    set_data(32'h6000_0000, 4);
    send_cmd(1'b0, 32'h0000_6000, 5'd4);
    wait_request(4);
    core_attempt(32'h0000_6000, 4'hC, 1'b0, 4, 1, 1'b1, 40'h40_0000_0000);
    exp_q.push_back(dat[0]);
    collect_end(2'b10, 5'd1, 1);
    @(negedge CLK); #1;
    chk("cmd_ready_after_abort", 40'(cmd_ready), 40'(1));

    // reset during S_XFER
    set_data(32'h7000_0000, 4);
    send_cmd(1'b0, 32'h0000_7000, 5'd4);
    wait_request(4);
    @(negedge CLK);
    m_addr_n = 1'b0;
    #1;
    chk("rst_xfer_addr", 40'(adio_in), 40'(32'h0000_7000));
    @(negedge CLK);
    m_addr_n = 1'b1;
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 40'(cmd_ready), 40'(1));
    chk("post_rst_request", 40'(request), 40'(0));
    chk("post_rst_done", 40'(done), 40'(0));
    chk("post_rst_adio_in", 40'(adio_in), 40'(0));
    chk("post_rst_m_ready", 40'(m_ready), 40'(0));
    chk("post_rst_m_wrdn", 40'(m_wrdn), 40'(0));

    // a fresh command after the reset runs normally
    set_data(32'hCAFE_F00D, 1);
    send_cmd(1'b0, 32'h0000_A000, 5'd1);
    wait_request(1);
    core_attempt(32'h0000_A000, 4'h6, 1'b0, 1, 1, 1'b0, 40'h0);
    exp_q.push_back(dat[0]);
    collect_end(2'b00, 5'd1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
